// File: rtl/alu_op_driver_if.sv
// Request, response and ALU-side signals of alu_op_driver.
// The slave modport is the driver itself; the master is the requester/ALU side.
interface alu_op_driver_if #(
    parameter int TAGW = 4
);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic [3:0]      req_f;
    logic [TAGW-1:0] req_tag;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_s;
    logic [TAGW-1:0] rsp_tag;
    logic            rsp_err;
    logic [31:0]     operand_a;
    logic [31:0]     operand_b;
    logic [3:0]      f;
    logic [31:0]     s;
    logic            busy;

    modport slave (
        input  req_valid, req_a, req_b, req_f, req_tag, rsp_ready, s,
        output req_ready, rsp_valid, rsp_s, rsp_tag, rsp_err,
               operand_a, operand_b, f, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_f, req_tag, rsp_ready, s,
        input  req_ready, rsp_valid, rsp_s, rsp_tag, rsp_err,
               operand_a, operand_b, f, busy
    );
endinterface

// File: rtl/alu_op_driver.sv
// Issue front-end for the combinational ALU: queues requests, holds operands for a
// settle window, samples s and returns it with its tag on a valid/ready channel.
//   state | meaning
//   IDLE  | nothing in flight, waiting for a queued request
//   WAIT  | operands driven, settle counter running down
//   RESP  | result presented, waiting for rsp_ready
module alu_op_driver #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    parameter int TAGW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_op_driver_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [31:0]     a;
        logic [31:0]     b;
        logic [3:0]      f;
        logic [TAGW-1:0] tag;
    } req_t;

    req_t            mem [DEPTH];
    req_t            head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [NW-1:0]   count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    state_t          state;
    state_t          state_nxt;
    logic            load;
    logic            capture;
    logic            handshake;
    logic [CW-1:0]   cnt;

    logic [31:0]     op_a;
    logic [31:0]     op_b;
    logic [3:0]      op_f;
    logic [TAGW-1:0] op_tag;
    logic            op_err;

    logic            rsp_valid_q;
    logic [31:0]     rsp_s_q;
    logic [TAGW-1:0] rsp_tag_q;
    logic            rsp_err_q;

    function automatic logic f_illegal(input logic [3:0] code);
        case (code)
            4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    assign full  = (count == NW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
    assign push  = bus.req_valid && bus.req_ready;
    assign pop   = load;

    // No bypass: a full FIFO refuses even when the FSM pops in the same cycle.
    assign bus.req_ready = !full && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{a: bus.req_a, b: bus.req_b, f: bus.req_f, tag: bus.req_tag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    load      = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    handshake = 1'b1;
                    if (!empty) begin
                        load      = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a        <= '0;
            op_b        <= '0;
            op_f        <= '0;
            op_tag      <= '0;
            op_err      <= 1'b0;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_s_q     <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (load) begin
                op_a   <= head.a;
                op_b   <= head.b;
                op_f   <= head.f;
                op_tag <= head.tag;
                op_err <= f_illegal(head.f);
                cnt    <= CW'(SETTLE);
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
            // Illegal codes still reach the ALU, but their result is masked.
            if (capture) begin
                rsp_valid_q <= 1'b1;
                rsp_s_q     <= op_err ? '0 : bus.s;
                rsp_tag_q   <= op_tag;
                rsp_err_q   <= op_err;
            end else if (handshake) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.operand_a = op_a;
    assign bus.operand_b = op_b;
    assign bus.f         = op_f;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_s     = rsp_s_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state != IDLE) || !empty;
endmodule
